// File: rtl/byte_serializer.sv
// Parallel-in, serial-out byte unloader: takes one DEPTH-lane word on a valid/ready
// handshake and emits lanes DEPTH-1 down to 0, one per beat. Macro BYTE_SERIALIZER_SKID_EN enables zero-gap streaming.
module byte_serializer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DEPTH*WIDTH-1:0] Din_par,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       Dout,
  output logic                   out_last,
  output logic                   busy
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // valid never waits on ready, and a producer holds its data until the transfer.

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       idx_dec;
  logic [DEPTH*WIDTH-1:0] hold;
  logic [WIDTH-1:0]       lane [DEPTH];
  logic                   accept;
  logic                   fire;
  logic                   final_beat;

  for (genvar k = 0; k < DEPTH; k++) begin : g_lane
    assign lane[k] = hold[k*WIDTH +: WIDTH];
  end

  assign accept     = in_valid && in_ready;
  assign fire       = out_valid && out_ready;
  assign final_beat = fire && (idx == '0);
  assign idx_dec    = idx - 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      // A skid-mode load on the final beat keeps the block in SHIFT.
      SHIFT:   if (final_beat && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    busy      = 1'b0;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
      end
      SHIFT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
`ifdef BYTE_SERIALIZER_SKID_EN
        in_ready  = (idx == '0) && out_ready;
`else
        in_ready  = 1'b0;
`endif
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Dout and out_last are registered so nothing on the input side reaches them combinationally.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold     <= '0;
      idx      <= '0;
      Dout     <= '0;
      out_last <= 1'b0;
    end else if (accept) begin
      hold     <= Din_par;
      idx      <= IDX_MAX;
      Dout     <= Din_par[(DEPTH-1)*WIDTH +: WIDTH];
      out_last <= 1'b0;
    end else if (fire) begin
      if (idx != '0) begin
        idx      <= idx_dec;
        Dout     <= lane[idx_dec];
        out_last <= (idx_dec == '0);
      end else begin
        out_last <= 1'b0;
      end
    end
  end

  a_idx_range: assert property (@(posedge clock) disable iff (reset) idx <= IDX_MAX);
  a_stall_hold: assert property (@(posedge clock) disable iff (reset)
    (out_valid && !out_ready) |=> (out_valid && $stable(Dout) && $stable(out_last) && $stable(idx)));
  a_last_lane0: assert property (@(posedge clock) disable iff (reset)
    out_valid |-> (out_last == (idx == '0)));

endmodule

// File: tb/tb_byte_serializer.sv
// Directed bench for byte_serializer: load, backpressure, ignored input, back-to-back,
// reset mid-word and a round trip through a 4-stage byte shift register.
module tb_byte_serializer;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] Din_par;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  Dout;
  logic        out_last;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  logic       exp_last_q[$];
  logic [7:0] got_q[$];
  logic       got_last_q[$];
  int         cyc_q[$];
  logic [7:0] tap [4];

  byte_serializer #(.WIDTH(8), .DEPTH(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Din_par   (Din_par),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Dout      (Dout),
    .out_last  (out_last),
    .busy      (busy)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Beat monitor and round-trip shift register, sampled mid-cycle.
  always @(negedge clock) begin
    cyc++;
    if (!reset && out_valid && out_ready) begin
      got_q.push_back(Dout);
      got_last_q.push_back(out_last);
      cyc_q.push_back(cyc);
      tap[3] = tap[2];
      tap[2] = tap[1];
      tap[1] = tap[0];
      tap[0] = Dout;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) begin
      exp_q.push_back(w[k*8 +: 8]);
      exp_last_q.push_back(k == 0);
    end
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      check({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
      check({tag, "_last"}, got_last_q.pop_front(), exp_last_q.pop_front());
    end
    got_q.delete();
    got_last_q.delete();
    exp_q.delete();
    exp_last_q.delete();
    cyc_q.delete();
  endtask

  // driver: present a word and hold it until it is accepted
  task automatic send_word(input logic [31:0] w);
    bit done = 0;
    Din_par  = w;
    in_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clock);
      if (in_ready) begin
        done = 1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
      end
    end
    if (!done) in_valid = 1'b0;
    check("send_accept", done, 1);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clock);
      if (!busy) done = 1;
    end
    check("idle_reached", done, 1);
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    Din_par   = '0;
    for (int i = 0; i < 4; i++) tap[i] = '0;

    // reset values
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_dout", Dout, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    @(posedge clock);
    #1;

    // basic load, consecutive beats, round trip into the shift register
    expect_word(32'hDDCCBBAA);
    send_word(32'hDDCCBBAA);
    wait_idle();
    check("load_in_ready", in_ready, 1);
    check("load_busy", busy, 0);
    check("load_out_valid", out_valid, 0);
    if (cyc_q.size() == 4) check("load_span", cyc_q[3] - cyc_q[0], 3);
    check("rt_q0", tap[0], 8'hAA);
    check("rt_q1", tap[1], 8'hBB);
    check("rt_q2", tap[2], 8'hCC);
    check("rt_q3", tap[3], 8'hDD);
    check_stream("load");

    // backpressure: stall after the first beat, Dout must hold CC
    expect_word(32'hDDCCBBAA);
    send_word(32'hDDCCBBAA);
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check("stall_dout", Dout, 8'hCC);
      check("stall_valid", out_valid, 1);
      check("stall_last", out_last, 0);
      @(posedge clock);
      #1;
    end
    out_ready = 1'b1;
    wait_idle();
    check_stream("stall");

    // in_valid while busy is ignored
    expect_word(32'hDDCCBBAA);
    send_word(32'hDDCCBBAA);
    Din_par  = 32'hFFFFFFFF;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    Din_par  = '0;
    wait_idle();
    repeat (3) @(posedge clock);
    #1;
    check("ign_busy", busy, 0);
    check_stream("ignore");

    // back-to-back words
    expect_word(32'h04030201);
    expect_word(32'h08070605);
    send_word(32'h04030201);
    send_word(32'h08070605);
    wait_idle();
    if (cyc_q.size() == 8) begin
`ifdef BYTE_SERIALIZER_SKID_EN
      check("b2b_span", cyc_q[7] - cyc_q[0], 7);
`else
      check("b2b_span", cyc_q[7] - cyc_q[0], 8);
`endif
    end
    check_stream("b2b");

    // reset mid-word discards the rest of the word
    exp_q.push_back(8'h44);
    exp_last_q.push_back(1'b0);
    exp_q.push_back(8'h33);
    exp_last_q.push_back(1'b0);
    send_word(32'h44332211);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("mrst_out_valid", out_valid, 0);
    check("mrst_in_ready", in_ready, 1);
    check("mrst_busy", busy, 0);
    check("mrst_dout", Dout, 0);
    check_stream("partial");
    @(posedge clock);
    #1;
    expect_word(32'h88776655);
    send_word(32'h88776655);
    wait_idle();
    check_stream("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
